// File: rtl/ram2wishbone_arb_bridge_if.sv
// Wishbone classic bus bundle between the arbitrating bridge (master) and the SoC bus (slave).
interface ram2wishbone_arb_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
);
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [SEL_WIDTH-1:0]  sel;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;
  logic                  err;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  rdata, ack, err
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output rdata, ack, err
  );
endinterface

// File: rtl/ram2wishbone_arb_bridge.sv
// Round-robin bridge from NUM_CH RAM-style pipeline ports onto one Wishbone classic master,
// with per-channel hold buffering, flush abort and bus-error/timeout reporting.
module ram2wishbone_arb_bridge #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic [NUM_CH-1:0]            ch_hold_i,
  input  logic [NUM_CH-1:0]            ch_ce_i,
  input  logic [NUM_CH-1:0]            ch_we_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i,
  input  logic [NUM_CH*SEL_WIDTH-1:0]  ch_sel_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_data_o,
  output logic [NUM_CH-1:0]            ch_stall_req,
  output logic [NUM_CH-1:0]            ch_err_o,
  ram2wishbone_arb_bridge_if.master    wb
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  logic [PTR_W-1:0]      gnt;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      winner;
  logic [PTR_W-1:0]      sel_ch;
  logic [PTR_W-1:0]      next_ptr;
  logic [SUM_W-1:0]      cand_sum;
  logic [NUM_CH-1:0]     done;
  logic [NUM_CH-1:0]     err_buf;
  logic [NUM_CH-1:0]     eligible;
  logic [CNT_W-1:0]      to_cnt;
  logic [DATA_WIDTH-1:0] data_buf [NUM_CH];
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_CH];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_CH];
  logic [SEL_WIDTH-1:0]  sel_arr [NUM_CH];
  logic                  any_eligible;
  logic                  timeout;
  logic                  bus_err;
  logic                  complete;
  logic                  done_now;

  // Gating with rst keeps the zero-latency issue path quiet while reset is held.
  assign eligible = ch_ce_i & ~done & {NUM_CH{~flush_i & ~rst}};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      addr_arr[i]  = ch_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = ch_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      sel_arr[i]   = ch_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
    end
  end

  // Scan downwards so the last hit is the first eligible channel at or after rr_ptr.
  always_comb begin
    winner       = '0;
    any_eligible = 1'b0;
    cand_sum     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_ptr} + SUM_W'(k);
      if (cand_sum >= SUM_W'(NUM_CH)) begin
        cand_sum = cand_sum - SUM_W'(NUM_CH);
      end
      if (eligible[cand_sum[PTR_W-1:0]]) begin
        winner       = cand_sum[PTR_W-1:0];
        any_eligible = 1'b1;
      end
    end
  end

  assign timeout  = (TIMEOUT_CYC != 0) && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign bus_err  = wb.err | timeout;
  assign complete = (state == BUSY) && (wb.ack || wb.err || timeout);
  assign done_now = complete & ~flush_i;
  assign next_ptr = (gnt == PTR_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
  assign sel_ch   = (state == BUSY) ? gnt : winner;

  // cyc/stb are decoded from state so an idle request reaches the bus in the same cycle.
  assign wb.cyc   = (state == BUSY) | any_eligible;
  assign wb.stb   = (state == BUSY) | any_eligible;
  assign wb.we    = ch_we_i[sel_ch];
  assign wb.addr  = addr_arr[sel_ch];
  assign wb.wdata = wdata_arr[sel_ch];
  assign wb.sel   = sel_arr[sel_ch];

  always_comb begin
    ch_data_o    = '0;
    ch_err_o     = '0;
    ch_stall_req = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_data_o[i*DATA_WIDTH +: DATA_WIDTH] = data_buf[i];
      ch_err_o[i]     = done[i] & err_buf[i];
      ch_stall_req[i] = eligible[i];
    end
    if (done_now) begin
      if (!ch_we_i[gnt]) begin
        ch_data_o[int'(gnt)*DATA_WIDTH +: DATA_WIDTH] = wb.rdata;
      end
      ch_err_o[gnt]     = bus_err;
      ch_stall_req[gnt] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      rr_ptr  <= '0;
      done    <= '0;
      err_buf <= '0;
      to_cnt  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        data_buf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ch_hold_i[i]) begin
          done[i] <= 1'b0;
        end
      end
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (any_eligible) begin
            gnt   <= winner;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
          if (flush_i) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end else if (complete) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
            if (!ch_we_i[gnt]) begin
              data_buf[gnt] <= wb.rdata;
            end
            if (ch_hold_i[gnt]) begin
              done[gnt]    <= 1'b1;
              err_buf[gnt] <= bus_err;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (flush_i) begin
        done <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram2wishbone_arb_bridge.sv
// Directed bench for the arbitrating RAM-to-Wishbone bridge: each step drives inputs just
// after a rising edge and then compares the live DUT outputs directly within that cycle.
module tb_ram2wishbone_arb_bridge;

   typedef enum int {S_CYC, S_STB, S_WE, S_ADDR, S_WDATA, S_SEL,
                     S_STALL, S_ERR, S_DATA0, S_DATA1} sig_t;

   logic        clock;
   logic        reset;
   logic        flush;
   logic [1:0]  hold;
   logic [1:0]  ce;
   logic [1:0]  we;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [7:0]  sel;
   logic [63:0] rdataCh;
   logic [1:0]  stall;
   logic [1:0]  errv;

   int nChecks = 0;
   int nFail   = 0;

   ram2wishbone_arb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4)) wb ();

   ram2wishbone_arb_bridge #(
      .NUM_CH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .TIMEOUT_CYC(8)
   ) dut (
      .clk          (clock),
      .rst          (reset),
      .flush_i      (flush),
      .ch_hold_i    (hold),
      .ch_ce_i      (ce),
      .ch_we_i      (we),
      .ch_addr_i    (addr),
      .ch_data_i    (wdata),
      .ch_sel_i     (sel),
      .ch_data_o    (rdataCh),
      .ch_stall_req (stall),
      .ch_err_o     (errv),
      .wb           (wb)
   );

   // Free-running clock with a 10 time-unit period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic reportFail(input string name, input logic [31:0] act, input logic [31:0] exp);
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic applyStimulus(input logic r, input logic [1:0] c, input logic [1:0] h,
                                input logic f, input logic a, input logic er,
                                input logic [31:0] rd);
      @(posedge clock);
      #1;
      reset    = r;
      ce       = c;
      hold     = h;
      flush    = f;
      wb.ack   = a;
      wb.err   = er;
      wb.rdata = rd;
      #1;
   endtask

   task automatic checkOutput(input string name, input sig_t s, input logic [31:0] v);
      nChecks++;
      case (s)
         S_CYC:   if (wb.cyc !== v[0])            reportFail(name, {31'b0, wb.cyc}, v);
         S_STB:   if (wb.stb !== v[0])            reportFail(name, {31'b0, wb.stb}, v);
         S_WE:    if (wb.we !== v[0])             reportFail(name, {31'b0, wb.we}, v);
         S_ADDR:  if (wb.addr !== v)              reportFail(name, wb.addr, v);
         S_WDATA: if (wb.wdata !== v)             reportFail(name, wb.wdata, v);
         S_SEL:   if (wb.sel !== v[3:0])          reportFail(name, {28'b0, wb.sel}, v);
         S_STALL: if (stall !== v[1:0])           reportFail(name, {30'b0, stall}, v);
         S_ERR:   if (errv !== v[1:0])            reportFail(name, {30'b0, errv}, v);
         S_DATA0: if (rdataCh[31:0] !== v)        reportFail(name, rdataCh[31:0], v);
         S_DATA1: if (rdataCh[63:32] !== v)       reportFail(name, rdataCh[63:32], v);
         default: reportFail(name, 32'hFFFF_FFFF, v);
      endcase
   endtask

   // Main directed sequence covering the six specification scenarios.
   initial begin
      reset = 1'b1; flush = 1'b0; hold = '0; ce = '0; we = '0;
      addr = {32'h0000_0200, 32'h0000_0100};
      wdata = '0; sel = 8'hFF;
      wb.ack = 1'b0; wb.err = 1'b0; wb.rdata = '0;

      applyStimulus(1, 2'b11, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("rst_cyc",   S_CYC,   32'd0);
      checkOutput("rst_stb",   S_STB,   32'd0);
      checkOutput("rst_stall", S_STALL, 32'd0);
      checkOutput("rst_err",   S_ERR,   32'd0);
      checkOutput("rst_data0", S_DATA0, 32'd0);
      checkOutput("rst_data1", S_DATA1, 32'd0);
      applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("idle_cyc", S_CYC, 32'd0);

      applyStimulus(0, 2'b01, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t1_issue_cyc",   S_CYC,   32'd1);
      checkOutput("t1_issue_addr",  S_ADDR,  32'h100);
      checkOutput("t1_issue_we",    S_WE,    32'd0);
      checkOutput("t1_issue_stall", S_STALL, 32'd1);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(0, 2'b01, 2'b00, 0, 0, 0, 32'h0);
         checkOutput("t1_wait_cyc",   S_CYC,   32'd1);
         checkOutput("t1_wait_stall", S_STALL, 32'd1);
      end
      applyStimulus(0, 2'b01, 2'b00, 0, 1, 0, 32'hDEAD_BEEF);
      checkOutput("t1_ack_cyc",   S_CYC,   32'd1);
      checkOutput("t1_ack_stall", S_STALL, 32'd0);
      checkOutput("t1_ack_data0", S_DATA0, 32'hDEAD_BEEF);
      checkOutput("t1_ack_err",   S_ERR,   32'd0);
      applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t1_after_cyc",   S_CYC,   32'd0);
      checkOutput("t1_after_data0", S_DATA0, 32'hDEAD_BEEF);

      applyStimulus(0, 2'b10, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t3_issue_addr",  S_ADDR,  32'h200);
      checkOutput("t3_issue_stall", S_STALL, 32'd2);
      applyStimulus(0, 2'b10, 2'b10, 0, 1, 0, 32'h1234_5678);
      checkOutput("t3_ack_data1", S_DATA1, 32'h1234_5678);
      checkOutput("t3_ack_stall", S_STALL, 32'd0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 2'b10, 2'b10, 0, 0, 0, 32'h0);
         checkOutput("t3_hold_cyc",   S_CYC,   32'd0);
         checkOutput("t3_hold_stall", S_STALL, 32'd0);
         checkOutput("t3_hold_data1", S_DATA1, 32'h1234_5678);
      end
      applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t3_rel_cyc", S_CYC, 32'd0);
      applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t3_rel_data1", S_DATA1, 32'h1234_5678);

      applyStimulus(0, 2'b11, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t2_first_addr",  S_ADDR,  32'h100);
      checkOutput("t2_first_stall", S_STALL, 32'd3);
      applyStimulus(0, 2'b11, 2'b00, 0, 1, 0, 32'hA0A0_A0A0);
      checkOutput("t2_ack0_stall", S_STALL, 32'd2);
      checkOutput("t2_ack0_data0", S_DATA0, 32'hA0A0_A0A0);
      applyStimulus(0, 2'b11, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t2_second_cyc",  S_CYC,  32'd1);
      checkOutput("t2_second_addr", S_ADDR, 32'h200);
      applyStimulus(0, 2'b11, 2'b00, 0, 1, 0, 32'hB1B1_B1B1);
      checkOutput("t2_ack1_stall", S_STALL, 32'd1);
      checkOutput("t2_ack1_data1", S_DATA1, 32'hB1B1_B1B1);
      applyStimulus(0, 2'b01, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t2_third_addr", S_ADDR, 32'h100);
      applyStimulus(0, 2'b01, 2'b00, 0, 1, 0, 32'hC2C2_C2C2);
      checkOutput("t2_ack2_data0", S_DATA0, 32'hC2C2_C2C2);
      applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t2_end_cyc", S_CYC, 32'd0);

      we[0] = 1'b1; addr[31:0] = 32'h300; wdata[31:0] = 32'h55AA_55AA; sel[3:0] = 4'h3;
      applyStimulus(0, 2'b01, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t4_issue_we",    S_WE,    32'd1);
      checkOutput("t4_issue_addr",  S_ADDR,  32'h300);
      checkOutput("t4_issue_wdata", S_WDATA, 32'h55AA_55AA);
      checkOutput("t4_issue_sel",   S_SEL,   32'h3);
      for (int k = 0; k < 7; k++) begin
         applyStimulus(0, 2'b01, 2'b00, 0, 0, 0, 32'h0);
         checkOutput("t4_wait_cyc", S_CYC, 32'd1);
         checkOutput("t4_wait_err", S_ERR, 32'd0);
      end
      applyStimulus(0, 2'b01, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t4_to_cyc",   S_CYC,   32'd1);
      checkOutput("t4_to_err",   S_ERR,   32'd1);
      checkOutput("t4_to_stall", S_STALL, 32'd0);
      checkOutput("t4_to_data0", S_DATA0, 32'hC2C2_C2C2);
      applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t4_post_cyc", S_CYC, 32'd0);
      checkOutput("t4_post_err", S_ERR, 32'd0);
      we[0] = 1'b0; addr[31:0] = 32'h100; wdata[31:0] = '0; sel[3:0] = 4'hF;

      applyStimulus(0, 2'b10, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t4b_issue_addr", S_ADDR, 32'h200);
      applyStimulus(0, 2'b10, 2'b00, 0, 1, 1, 32'h7777_7777);
      checkOutput("t4b_err", S_ERR, 32'd2);
      applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t4b_post_err", S_ERR, 32'd0);

      applyStimulus(0, 2'b01, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t5_issue_addr", S_ADDR, 32'h100);
      applyStimulus(0, 2'b01, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t5_busy1_stall", S_STALL, 32'd1);
      applyStimulus(0, 2'b01, 2'b00, 1, 1, 0, 32'h9999_9999);
      checkOutput("t5_flush_cyc",   S_CYC,   32'd1);
      checkOutput("t5_flush_stall", S_STALL, 32'd0);
      checkOutput("t5_flush_err",   S_ERR,   32'd0);
      checkOutput("t5_flush_data0", S_DATA0, 32'hC2C2_C2C2);
      applyStimulus(0, 2'b11, 2'b00, 1, 0, 0, 32'h0);
      checkOutput("t5_pend_cyc",   S_CYC,   32'd0);
      checkOutput("t5_pend_stall", S_STALL, 32'd0);
      applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t5_end_data0", S_DATA0, 32'hC2C2_C2C2);

      applyStimulus(0, 2'b10, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t6_issue_addr", S_ADDR, 32'h200);
      applyStimulus(0, 2'b10, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t6_busy_cyc", S_CYC, 32'd1);
      applyStimulus(1, 2'b10, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t6_rst_cyc",   S_CYC,   32'd0);
      checkOutput("t6_rst_stb",   S_STB,   32'd0);
      checkOutput("t6_rst_stall", S_STALL, 32'd0);
      checkOutput("t6_rst_data1", S_DATA1, 32'd0);
      applyStimulus(0, 2'b11, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t6_after_addr",  S_ADDR,  32'h100);
      checkOutput("t6_after_stall", S_STALL, 32'd3);
      applyStimulus(0, 2'b11, 2'b00, 0, 1, 0, 32'h0BAD_F00D);
      checkOutput("t6_ack_data0", S_DATA0, 32'h0BAD_F00D);
      checkOutput("t6_ack_stall", S_STALL, 32'd2);
      applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 32'h0);
      checkOutput("t6_end_cyc", S_CYC, 32'd0);

      repeat (2) @(posedge clock);
      if (nFail == 0) begin
         $display("[TB] PASS");
      end else begin
         $display("[TB] FAIL: %0d failures", nFail);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
